// File: rtl/switching_merge.sv
`default_nettype none
// ============================================================================
// Module      : switching_merge
// Description : Rebuilds the parent code, switching magnitude and PN polarity
//               of one DEM tree node from its two branch codes. It also
//               checks parity and tracks the saturating switching integral.
// Revision    : 1.0 - initial release
// ============================================================================
module switching_merge #(
    parameter int WIDTH = 5,
    parameter int ACC_W = 8,
    parameter int CNT_W = 8,
    parameter int BOUND = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] x1_i,
    input  logic [WIDTH-1:0] x2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] s_o,
    output logic             pn_o,
    output logic             parity_err_o,
    output logic [ACC_W-1:0] acc_o,
    output logic             bound_err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    // Working width wide enough for acc +/- s without wrap before saturation.
    localparam int c_EXT_W = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;
    localparam logic signed [c_EXT_W-1:0] c_ACC_MAX =
        {{(c_EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [c_EXT_W-1:0] c_ACC_MIN =
        {{(c_EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic [c_EXT_W-1:0] c_BOUND = c_EXT_W'(BOUND);

    logic                      r_alive;
    logic                      r_s1_valid;
    logic [WIDTH:0]            r_sum;
    logic [WIDTH:0]            r_diff;
    logic                      r_s2_valid;
    logic [WIDTH-1:0]          r_x;
    logic [WIDTH-1:0]          r_s;
    logic                      r_pn;
    logic                      r_perr;
    logic [ACC_W-1:0]          r_acc;
    logic                      r_bound;
    logic [CNT_W-1:0]          r_cnt;

    logic                      w_en;
    logic                      w_in_xfer;
    logic                      w_load;
    logic [WIDTH:0]            w_diff_mag;
    logic [WIDTH-1:0]          w_x;
    logic [WIDTH-1:0]          w_s;
    logic                      w_pn;
    logic                      w_perr;
    logic signed [c_EXT_W-1:0] w_acc_ext;
    logic signed [c_EXT_W-1:0] w_s_ext;
    logic signed [c_EXT_W-1:0] w_acc_sum;
    logic [ACC_W-1:0]          w_acc_next;
    logic signed [c_EXT_W-1:0] w_acc_next_ext;
    logic [c_EXT_W-1:0]        w_acc_mag;
    logic                      w_bound_hit;

    // r_alive keeps ready low for the first cycle after reset release.
    assign w_en      = r_alive & (~r_s2_valid | ready_i);
    assign w_in_xfer = valid_i & w_en;
    assign w_load    = w_en & r_s1_valid;

    assign w_diff_mag = r_diff[WIDTH] ? -r_diff : r_diff;
    assign w_x        = r_sum[WIDTH:1];
    assign w_s        = w_diff_mag[WIDTH:1];
    assign w_pn       = ~r_diff[WIDTH] & (|r_diff);
    assign w_perr     = r_sum[0] | w_diff_mag[0] | (w_s[0] ^ w_x[0]);

    assign w_acc_ext = {{(c_EXT_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
    assign w_s_ext   = {{(c_EXT_W-WIDTH){1'b0}}, w_s};
    assign w_acc_sum = w_pn ? (w_acc_ext + w_s_ext) : (w_acc_ext - w_s_ext);

    always_comb begin
        w_acc_next = w_acc_sum[ACC_W-1:0];
        if (w_acc_sum > c_ACC_MAX) begin
            w_acc_next = c_ACC_MAX[ACC_W-1:0];
        end else if (w_acc_sum < c_ACC_MIN) begin
            w_acc_next = c_ACC_MIN[ACC_W-1:0];
        end
    end

    assign w_acc_next_ext = {{(c_EXT_W-ACC_W){w_acc_next[ACC_W-1]}}, w_acc_next};
    assign w_acc_mag      = w_acc_next[ACC_W-1] ? -w_acc_next_ext : w_acc_next_ext;
    assign w_bound_hit    = (w_acc_mag > c_BOUND);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_alive    <= 1'b0;
            r_s1_valid <= 1'b0;
            r_sum      <= '0;
            r_diff     <= '0;
            r_s2_valid <= 1'b0;
            r_x        <= '0;
            r_s        <= '0;
            r_pn       <= 1'b0;
            r_perr     <= 1'b0;
            r_acc      <= '0;
            r_bound    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_alive <= 1'b1;

            if (w_in_xfer) begin
                r_s1_valid <= 1'b1;
                r_sum      <= {1'b0, x1_i} + {1'b0, x2_i};
                r_diff     <= {1'b0, x1_i} - {1'b0, x2_i};
            end else if (w_en) begin
                r_s1_valid <= 1'b0;
            end

            if (w_en) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_load) begin
                r_x    <= w_x;
                r_s    <= w_s;
                r_pn   <= w_pn;
                r_perr <= w_perr;
            end

            // Clear wins over any update landing on the same edge.
            if (clear_i) begin
                r_acc   <= '0;
                r_bound <= 1'b0;
                r_cnt   <= '0;
            end else if (w_load) begin
                if (w_perr) begin
                    if (r_cnt != {CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end else begin
                    r_acc <= w_acc_next;
                    if (w_bound_hit) begin
                        r_bound <= 1'b1;
                    end
                end
            end
        end
    end

    assign ready_o      = w_en;
    assign valid_o      = r_s2_valid;
    assign x_o          = r_x;
    assign s_o          = r_s;
    assign pn_o         = r_pn;
    assign parity_err_o = r_perr;
    assign acc_o        = r_acc;
    assign bound_err_o  = r_bound;
    assign err_cnt_o    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_switching_merge.sv
`default_nettype none
// ============================================================================
// Module      : tb_switching_merge
// Description : Randomised and directed bench for switching_merge against a
//               transaction-level reference model with an in-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switching_merge;

    localparam int WIDTH = 5;
    localparam int ACC_W = 8;
    localparam int CNT_W = 8;
    localparam int BOUND = 16;
    localparam int c_ACC_MAX = 2**(ACC_W-1) - 1;
    localparam int c_ACC_MIN = -(2**(ACC_W-1));
    localparam int c_CNT_MAX = 2**CNT_W - 1;

    logic             clk_i   = 1'b0;
    logic             reset_i = 1'b1;
    logic             clear_i = 1'b0;
    logic             valid_i = 1'b0;
    logic             ready_i = 1'b0;
    logic [WIDTH-1:0] x1_i    = '0;
    logic [WIDTH-1:0] x2_i    = '0;
    logic             ready_o;
    logic             valid_o;
    logic [WIDTH-1:0] x_o;
    logic [WIDTH-1:0] s_o;
    logic             pn_o;
    logic             parity_err_o;
    logic [ACC_W-1:0] acc_o;
    logic             bound_err_o;
    logic [CNT_W-1:0] err_cnt_o;

    switching_merge #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W),
        .BOUND (BOUND)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clear_i      (clear_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .x1_i         (x1_i),
        .x2_i         (x2_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .x_o          (x_o),
        .s_o          (s_o),
        .pn_o         (pn_o),
        .parity_err_o (parity_err_o),
        .acc_o        (acc_o),
        .bound_err_o  (bound_err_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int a;
        int b;
        int t;
    } pair_t;

    pair_t q[$];
    int    n_total = 0;
    int    n_bad   = 0;
    int    cyc     = 0;
    int    m_acc   = 0;
    int    m_cnt   = 0;
    bit    m_bnd   = 1'b0;
    bit    alive   = 1'b0;
    bit    fresh   = 1'b1;
    bit    lat_chk = 1'b0;
    bit    took;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid_o"}, valid_o, 0);
        check({tag, "_ready_o"}, ready_o, 0);
        check({tag, "_x_o"}, x_o, 0);
        check({tag, "_s_o"}, s_o, 0);
        check({tag, "_pn_o"}, pn_o, 0);
        check({tag, "_parity_err_o"}, parity_err_o, 0);
        check({tag, "_acc_o"}, $signed(acc_o), 0);
        check({tag, "_bound_err_o"}, bound_err_o, 0);
        check({tag, "_err_cnt_o"}, err_cnt_o, 0);
    endtask

    // Reference behaviour: results are computed per transaction when they
    // first appear on the output, in acceptance order.
    task automatic observe();
        pair_t e;
        int    sum, diff, ex, es, epn, eperr, mag;
        if (valid_o) begin
            if (fresh) begin
                fresh = 1'b0;
                if (q.size() == 0) begin
                    check("spurious_result", 1, 0);
                end else begin
                    e     = q.pop_front();
                    sum   = e.a + e.b;
                    diff  = e.a - e.b;
                    ex    = sum / 2;
                    es    = (diff < 0 ? -diff : diff) / 2;
                    epn   = (diff > 0) ? 1 : 0;
                    eperr = ((sum % 2) != 0 || (ex % 2) != (es % 2)) ? 1 : 0;
                    if (lat_chk) check("latency", cyc - e.t, 2);
                    check("x_o", x_o, ex);
                    check("s_o", s_o, es);
                    check("pn_o", pn_o, epn);
                    check("parity_err_o", parity_err_o, eperr);
                    if (eperr == 0) begin
                        m_acc = m_acc + (epn != 0 ? es : -es);
                        if (m_acc > c_ACC_MAX) m_acc = c_ACC_MAX;
                        if (m_acc < c_ACC_MIN) m_acc = c_ACC_MIN;
                        mag = (m_acc < 0) ? -m_acc : m_acc;
                        if (mag > BOUND) m_bnd = 1'b1;
                    end else if (m_cnt < c_CNT_MAX) begin
                        m_cnt++;
                    end
                end
            end
        end else begin
            fresh = 1'b1;
        end
        check("acc_o", $signed(acc_o), m_acc);
        check("err_cnt_o", err_cnt_o, m_cnt);
        check("bound_err_o", bound_err_o, m_bnd);
    endtask

    task automatic step(input bit vi, input int a, input int b, input bit ri,
                        input bit clr, output bit accepted);
        bit exp_ready;
        @(negedge clk_i);
        observe();
        valid_i = vi;
        x1_i    = a[WIDTH-1:0];
        x2_i    = b[WIDTH-1:0];
        ready_i = ri;
        clear_i = clr;
        #1;
        exp_ready = alive && (!valid_o || ri);
        check("ready_o", ready_o, exp_ready);
        accepted = vi && exp_ready;
        if (accepted) q.push_back('{a, b, cyc});
        if (valid_o && ri) fresh = 1'b1;
        @(posedge clk_i);
        cyc++;
        alive = 1'b1;
        if (clr) begin
            m_acc = 0;
            m_cnt = 0;
            m_bnd = 1'b0;
        end
    endtask

    task automatic send(input int a, input int b);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) step(1'b1, a, b, 1'b1, 1'b0, ok);
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n, input bit clr);
        bit dummy;
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b1, clr, dummy);
    endtask

    task automatic drain();
        bit dummy;
        for (int i = 0; i < 30 && q.size() > 0; i++) step(1'b0, 0, 0, 1'b1, 1'b0, dummy);
        check("drain_pending", q.size(), 0);
    endtask

    task automatic release_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        check("ready_after_release", ready_o, 0);
        @(posedge clk_i);
        alive = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check_zero("reset");
        release_reset();

        // Known-answer pairs, back to back, with latency checked.
        lat_chk = 1'b1;
        send(14, 6);
        send(6, 14);
        send(10, 4);
        drain();
        lat_chk = 1'b0;
        #1;
        check("tp_acc_after_three", $signed(acc_o), 3);

        send(13, 6);
        drain();
        #1;
        check("tp_err_cnt_one", err_cnt_o, 1);
        check("tp_acc_unchanged", $signed(acc_o), 3);

        repeat (299) send(13, 6);
        drain();
        #1;
        check("tp_err_cnt_sat", err_cnt_o, 255);

        // Five-pair stream with a 3-cycle downstream stall in the middle.
        send(1, 3);
        send(7, 9);
        send(20, 4);
        for (int i = 0; i < 3; i++) step(1'b1, 5, 5, 1'b0, 1'b0, took);
        send(5, 5);
        send(2, 30);
        drain();

        idle(1, 1'b1);
        #1;
        check("clear_acc", $signed(acc_o), 0);
        check("clear_cnt", err_cnt_o, 0);
        check("clear_bound", bound_err_o, 0);

        repeat (12) send(30, 0);
        drain();
        #1;
        check("sat_acc", $signed(acc_o), 127);
        check("sat_bound", bound_err_o, 1);
        idle(1, 1'b1);
        #1;
        check("clear2_acc", $signed(acc_o), 0);
        check("clear2_bound", bound_err_o, 0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), $urandom_range(0, 3) != 0, 1'b0, took);
        end
        drain();

        // Asynchronous reset with two samples in flight.
        send(3, 9);
        send(11, 1);
        #2;
        reset_i = 1'b1;
        #1;
        check_zero("midrst");
        q.delete();
        m_acc = 0;
        m_cnt = 0;
        m_bnd = 1'b0;
        alive = 1'b0;
        fresh = 1'b1;
        @(posedge clk_i);
        release_reset();
        idle(5, 1'b0);
        #1;
        check("post_reset_valid", valid_o, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
